// File: rtl/bit_entry_pkg.sv
// Shared types and default parameters for the bit-entry front end.
package bit_entry_pkg;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_WAIT_RELEASE = 3'd2,
    S_VERIFY       = 3'd3,
    S_DONE         = 3'd4
  } bit_entry_state_t;

  localparam int unsigned NUM_BITS_DEF        = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 1_000_000;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter, registered debounced level and
// a registered single-cycle rise strobe that coincides with the level rising.
module button_debouncer
  import bit_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Final differing sample: flip now so rise aligns with the new level.
        level <= ~level;
        rise  <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_entry_controller.sv
// Button-driven bit entry sequencer feeding the answer shift register.
// Optional WAIT_PRESS inactivity abort is enabled by defining BIT_ENTRY_TIMEOUT_EN.
module bit_entry_controller
  import bit_entry_pkg::*;
#(
  parameter int unsigned NUM_BITS        = NUM_BITS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             btn1_raw,
  input  logic                             btn2_raw,
  input  logic                             start,
  output logic                             bit_valid,
  output logic                             bit_value,
  output logic [$clog2(NUM_BITS+1)-1:0]    bit_count,
  output logic                             waiting_for_user,
  output logic                             start_verification,
  output logic                             done,
  output logic                             timeout
);

  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  bit_entry_state_t   state_q, state_d;
  logic               bit_valid_d, bit_value_d;
  logic [CNT_W-1:0]   bit_count_d;
  logic               waiting_d, start_ver_d, done_d;
  logic               level1, rise1, level2, rise2;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn1 (
    .clk   (clk),
    .rst_n (rst),
    .raw   (btn1_raw),
    .level (level1),
    .rise  (rise1)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn2 (
    .clk   (clk),
    .rst_n (rst),
    .raw   (btn2_raw),
    .level (level2),
    .rise  (rise2)
  );

`ifdef BIT_ENTRY_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= S_IDLE;
      bit_valid          <= 1'b0;
      bit_value          <= 1'b0;
      bit_count          <= '0;
      waiting_for_user   <= 1'b0;
      start_verification <= 1'b0;
      done               <= 1'b0;
`ifdef BIT_ENTRY_TIMEOUT_EN
      to_cnt_q           <= '0;
      timeout            <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      bit_valid          <= bit_valid_d;
      bit_value          <= bit_value_d;
      bit_count          <= bit_count_d;
      waiting_for_user   <= waiting_d;
      start_verification <= start_ver_d;
      done               <= done_d;
`ifdef BIT_ENTRY_TIMEOUT_EN
      to_cnt_q           <= to_cnt_d;
      timeout            <= timeout_d;
`endif
    end
  end

`ifndef BIT_ENTRY_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  // Status flags are registered from the next state so they line up with state_q.
  always_comb begin
    state_d     = state_q;
    bit_valid_d = 1'b0;
    bit_value_d = bit_value;
    bit_count_d = bit_count;
`ifdef BIT_ENTRY_TIMEOUT_EN
    to_cnt_d    = '0;
    timeout_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT_PRESS;
          bit_count_d = '0;
        end
      end
      S_WAIT_PRESS: begin
        if (rise1 && rise2) begin
          state_d = S_WAIT_RELEASE;
        end else if (rise1 || rise2) begin
          bit_valid_d = 1'b1;
          bit_value_d = rise1;
          bit_count_d = bit_count + 1'b1;
          state_d     = S_WAIT_RELEASE;
        end
`ifdef BIT_ENTRY_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          timeout_d   = 1'b1;
          bit_count_d = '0;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      S_WAIT_RELEASE: begin
        if (!level1 && !level2) begin
          state_d = (bit_count == CNT_W'(NUM_BITS)) ? S_VERIFY : S_WAIT_PRESS;
        end
      end
      S_VERIFY: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d     = S_WAIT_PRESS;
          bit_count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    waiting_d   = (state_d == S_WAIT_PRESS) || (state_d == S_WAIT_RELEASE);
    start_ver_d = (state_d == S_VERIFY);
    done_d      = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_bit_entry_controller.sv
// Directed/randomized bench for bit_entry_controller with a session-level reference model.
module tb_bit_entry_controller;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned TO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn1_raw = 1'b0;
  logic       btn2_raw = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid, bit_value, waiting_for_user, start_verification, done, timeout;
  logic [2:0] bit_count;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned strobes = 0;
  int unsigned sv_cycles = 0;
  int unsigned to_cycles = 0;
  int unsigned exp_count = 0;

  bit_entry_controller #(
    .NUM_BITS        (NB),
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn1_raw           (btn1_raw),
    .btn2_raw           (btn2_raw),
    .start              (start),
    .bit_valid          (bit_valid),
    .bit_value          (bit_value),
    .bit_count          (bit_count),
    .waiting_for_user   (waiting_for_user),
    .start_verification (start_verification),
    .done               (done),
    .timeout            (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Observers: pulse widths and cross-output relationships.
  logic prev_wait = 1'b0;
  logic prev_sv   = 1'b0;
  always @(posedge clk) begin
    #1;
    if (bit_valid) begin
      strobes++;
      check("bv_sv_exclusive", {31'b0, start_verification}, 32'd0);
    end
    if (start_verification) sv_cycles++;
    if (timeout) to_cycles++;
    if (start_verification && !prev_sv) begin
      check("sv_wait_fall_now", {31'b0, waiting_for_user}, 32'd0);
      check("sv_wait_high_before", {31'b0, prev_wait}, 32'd1);
    end
    prev_wait = waiting_for_user;
    prev_sv   = start_verification;
  end

  // Press one (which==1 -> btn1, else btn2) or both (which==3) buttons and hold.
  task automatic press(input int unsigned which, input bit accept, input string tag);
    bit seen;
    int unsigned lat;
    seen = 1'b0;
    lat  = 0;
    if (which == 1 || which == 3) btn1_raw = 1'b1;
    if (which == 2 || which == 3) btn2_raw = 1'b1;
    for (int i = 0; i < int'(DB) + 8; i++) begin
      @(posedge clk);
      #1;
      if (bit_valid && !seen) begin
        seen = 1'b1;
        lat  = i;
        check({tag, "_value"}, {31'b0, bit_value}, (which == 1) ? 32'd1 : 32'd0);
      end
    end
    if (accept) begin
      exp_count++;
      check({tag, "_seen"}, {31'b0, seen}, 32'd1);
      check({tag, "_latency"}, lat, DB + 2);
    end else begin
      check({tag, "_rejected"}, {31'b0, seen}, 32'd0);
    end
    check({tag, "_count"}, {29'b0, bit_count}, exp_count);
    tick($urandom_range(1, 4));
  endtask

  task automatic release_all();
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;
    tick(DB + 4);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_valid"}, {31'b0, bit_valid}, 32'd0);
    check({tag, "_bit_value"}, {31'b0, bit_value}, 32'd0);
    check({tag, "_bit_count"}, {29'b0, bit_count}, 32'd0);
    check({tag, "_waiting"}, {31'b0, waiting_for_user}, 32'd0);
    check({tag, "_start_ver"}, {31'b0, start_verification}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_timeout"}, {31'b0, timeout}, 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned bits[4];
    int unsigned s0, sv0, to0, idx;
    bit found;

    // Reset state.
    tick(3);
    check_all_zero("reset");
    rst = 1'b1;
    tick(2);

    // Session 1: fixed pattern 1,0,1,1.
    bits = '{1, 2, 1, 1};
    pulse_start();
    exp_count = 0;
    check("s1_waiting", {31'b0, waiting_for_user}, 32'd1);
    check("s1_count0", {29'b0, bit_count}, 32'd0);
    sv0 = sv_cycles;
    for (int i = 0; i < 4; i++) begin
      press(bits[i], 1'b1, "s1_press");
      release_all();
    end
    check("s1_sv_single", sv_cycles - sv0, 32'd1);
    check("s1_done", {31'b0, done}, 32'd1);
    check("s1_count_final", {29'b0, bit_count}, NB);
    check("s1_waiting_off", {31'b0, waiting_for_user}, 32'd0);

    // Session 2: glitches, simultaneous press, overlapping hold.
    pulse_start();
    exp_count = 0;
    check("s2_count_cleared", {29'b0, bit_count}, 32'd0);
    check("s2_done_off", {31'b0, done}, 32'd0);
    s0 = strobes;
    for (int unsigned g = 1; g <= DB - 1; g++) begin
      btn1_raw = 1'b1;
      tick(g);
      btn1_raw = 1'b0;
      tick(DB + 4);
    end
    check("glitch_no_strobe", strobes - s0, 32'd0);
    check("glitch_count", {29'b0, bit_count}, 32'd0);

    press(3, 1'b0, "both");
    release_all();
    check("both_waiting", {31'b0, waiting_for_user}, 32'd1);
    press(2, 1'b1, "after_both");

    release_all();
    s0 = strobes;
    press(1, 1'b1, "hold1");
    btn2_raw = 1'b1;
    tick(DB + 6);
    btn1_raw = 1'b0;
    tick(DB + 4);
    check("hold_still_waiting", {31'b0, waiting_for_user}, 32'd1);
    btn2_raw = 1'b0;
    tick(DB + 4);
    check("hold_one_strobe", strobes - s0, 32'd1);
    check("hold_count", {29'b0, bit_count}, 32'd2);

    // Asynchronous reset mid-session with btn1 held through release.
    btn1_raw = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    tick(2);
    rst = 1'b1;
    tick(DB + 6);
    s0 = strobes;
    pulse_start();
    exp_count = 0;
    tick(DB + 6);
    check("held_no_strobe", strobes - s0, 32'd0);
    check("held_count", {29'b0, bit_count}, 32'd0);
    check("held_waiting", {31'b0, waiting_for_user}, 32'd1);
    release_all();

    // Session 3: random buttons against the model, preceded by random short glitches.
    sv0 = sv_cycles;
    for (int i = 0; i < 4; i++) begin
      bits[i] = $urandom_range(1, 2);
      if (bits[i] == 1) btn2_raw = 1'b1; else btn1_raw = 1'b1;
      tick($urandom_range(1, DB - 1));
      btn1_raw = 1'b0;
      btn2_raw = 1'b0;
      tick(DB + 4);
      press(bits[i], 1'b1, "rnd_press");
      if (i < 3) begin
        start = 1'b1;
      end
      release_all();
      start = 1'b0;
    end
    check("rnd_sv_single", sv_cycles - sv0, 32'd1);
    check("rnd_done", {31'b0, done}, 32'd1);
    check("rnd_count_final", {29'b0, bit_count}, NB);

    // Timeout behaviour.
    pulse_start();
    exp_count = 0;
    sv0 = sv_cycles;
    to0 = to_cycles;
`ifdef BIT_ENTRY_TIMEOUT_EN
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= int'(TO) + 10; i++) begin
      @(posedge clk);
      #1;
      if (timeout && !found) begin
        found = 1'b1;
        idx   = i;
      end
    end
    check("to_seen", {31'b0, found}, 32'd1);
    check("to_cycle", idx, TO);
    check("to_single", to_cycles - to0, 32'd1);
    check("to_idle_wait", {31'b0, waiting_for_user}, 32'd0);
    check("to_idle_done", {31'b0, done}, 32'd0);
    check("to_count", {29'b0, bit_count}, 32'd0);
    check("to_no_sv", sv_cycles - sv0, 32'd0);
`else
    found = 1'b0;
    idx   = 0;
    tick(TO + 10);
    check("noto_waiting", {31'b0, waiting_for_user}, 32'd1);
    check("noto_pulses", to_cycles - to0, 32'd0);
    check("noto_no_sv", sv_cycles - sv0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
